// File: rtl/clk_cmp_pkg.sv
// Shared definitions for the frequency-comparator lock detector:
// relation encodings, FSM state type and the flag-to-relation decoder.
package clk_cmp_pkg;

    localparam logic [1:0] REL_NONE = 2'b00;
    localparam logic [1:0] REL_EQ   = 2'b01;
    localparam logic [1:0] REL_LT   = 2'b10;
    localparam logic [1:0] REL_GT   = 2'b11;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Decode {PeqQ, PleQ, PgrQ}; anything not exactly one-hot maps to REL_NONE,
    // so "valid" is simply "decoded relation is not REL_NONE".
    function automatic logic [1:0] flags_to_rel(input logic [2:0] flags);
        case (flags)
            3'b100:  return REL_EQ;
            3'b010:  return REL_LT;
            3'b001:  return REL_GT;
            default: return REL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear and load.
// Priority: clear, then load, then increment; holds at all-ones.
module sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] r_cnt;

    // Counter register: clear beats load beats increment, never wraps.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/clk_cmp_lock.sv
// Lock detector for a P/Q frequency comparator. Flags are registered once;
// a SEARCH/LOCKED FSM qualifies a relation after LOCK_CNT identical valid
// samples and drops it after UNLOCK_CNT consecutive non-matching samples.
module clk_cmp_lock
    import clk_cmp_pkg::*;
#(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       PeqQ,
    input  logic       PleQ,
    input  logic       PgrQ,
    input  logic       clr_stats,
    output logic       locked,
    output logic [1:0] rel,
    output logic       err_onehot,
    output logic [7:0] loss_cnt
);

    // Compare against "count before this edge", i.e. the edge that would reach the target.
    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_CNT - 1);

    logic [2:0] r_sample;
    logic       r_primed;   // sample register holds a real capture, not the reset value
    logic       r_err;
    state_t     r_state;
    logic [1:0] r_rel;
    logic [1:0] r_cand;

    state_t     w_state_nxt;
    logic [1:0] w_rel_nxt;
    logic [1:0] w_cand_nxt;
    logic [1:0] w_smp_rel;
    logic       w_valid;
    logic       w_run_clr;
    logic       w_run_load;
    logic       w_run_inc;
    logic       w_mis_clr;
    logic       w_mis_inc;
    logic       w_loss_inc;
    logic [7:0] w_run_cnt;
    logic [7:0] w_mis_cnt;

    assign w_smp_rel = flags_to_rel(r_sample);
    assign w_valid   = (w_smp_rel != REL_NONE);

    // Sample stage: capture comparator flags and flag non-one-hot samples one cycle later.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_sample <= 3'b000;
            r_primed <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_sample <= {PeqQ, PleQ, PgrQ};
            r_primed <= 1'b1;
            r_err    <= r_primed && !w_valid;
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Locked relation and search candidate registers.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_rel  <= REL_NONE;
            r_cand <= REL_NONE;
        end else begin
            r_rel  <= w_rel_nxt;
            r_cand <= w_cand_nxt;
        end
    end

    // Next-state and counter-control decode from the registered sample.
    // NOTE: every signal gets a default before any branch; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_rel_nxt   = r_rel;
        w_cand_nxt  = r_cand;
        w_run_clr   = 1'b0;
        w_run_load  = 1'b0;
        w_run_inc   = 1'b0;
        w_mis_clr   = 1'b0;
        w_mis_inc   = 1'b0;
        w_loss_inc  = 1'b0;
        if (r_primed) begin
            unique case (r_state)
                ST_SEARCH: begin
                    if (!w_valid) begin
                        w_run_clr = 1'b1;
                    end else if (w_smp_rel != r_cand) begin
                        w_run_load = 1'b1;
                        w_cand_nxt = w_smp_rel;
                    end else begin
                        w_run_inc = 1'b1;
                        if (w_run_cnt == LOCK_LAST) begin
                            w_state_nxt = ST_LOCKED;
                            w_rel_nxt   = r_cand;
                            w_mis_clr   = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    // r_rel is never REL_NONE here, so invalid samples mismatch.
                    if (w_smp_rel == r_rel) begin
                        w_mis_clr = 1'b1;
                    end else if (w_mis_cnt == UNLOCK_LAST) begin
                        w_state_nxt = ST_SEARCH;
                        w_rel_nxt   = REL_NONE;
                        w_loss_inc  = 1'b1;
                        w_mis_clr   = 1'b1;
                        if (w_valid) begin
                            w_run_load = 1'b1;
                            w_cand_nxt = w_smp_rel;
                        end else begin
                            w_run_clr = 1'b1;
                        end
                    end else begin
                        w_mis_inc = 1'b1;
                    end
                end
            endcase
        end
    end

    sat_cnt #(.WIDTH(8)) u_run_cnt (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .i_clr      (w_run_clr),
        .i_load     (w_run_load),
        .i_load_val (8'd1),
        .i_inc      (w_run_inc),
        .o_cnt      (w_run_cnt)
    );

    sat_cnt #(.WIDTH(8)) u_mis_cnt (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .i_clr      (w_mis_clr),
        .i_load     (1'b0),
        .i_load_val (8'd0),
        .i_inc      (w_mis_inc),
        .o_cnt      (w_mis_cnt)
    );

    // Clear has priority, so clr_stats wins over a coincident loss.
    sat_cnt #(.WIDTH(8)) u_loss_cnt (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .i_clr      (clr_stats),
        .i_load     (1'b0),
        .i_load_val (8'd0),
        .i_inc      (w_loss_inc),
        .o_cnt      (loss_cnt)
    );

    assign locked     = (r_state == ST_LOCKED);
    assign rel        = r_rel;
    assign err_onehot = r_err;

endmodule

// File: tb/tb_clk_cmp_lock.sv
// Self-checking bench for clk_cmp_lock: a cycle model pushes expected outputs
// into a scoreboard queue on each drive, popped and compared after the edge,
// plus directed checks of the lock/unlock timing scenarios.
module tb_clk_cmp_lock;

    localparam int LOCK_CNT   = 8;
    localparam int UNLOCK_CNT = 4;

    localparam bit [2:0] F_EQ   = 3'b100;
    localparam bit [2:0] F_LT   = 3'b010;
    localparam bit [2:0] F_GT   = 3'b001;
    localparam bit [2:0] F_NONE = 3'b000;

    logic       sys_clk;
    logic       rst;
    logic       PeqQ;
    logic       PleQ;
    logic       PgrQ;
    logic       clr_stats;
    logic       locked;
    logic [1:0] rel;
    logic       err_onehot;
    logic [7:0] loss_cnt;

    clk_cmp_lock #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .PeqQ       (PeqQ),
        .PleQ       (PleQ),
        .PgrQ       (PgrQ),
        .clr_stats  (clr_stats),
        .locked     (locked),
        .rel        (rel),
        .err_onehot (err_onehot),
        .loss_cnt   (loss_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic       locked;
        logic [1:0] rel;
        logic       err;
        logic [7:0] loss;
    } exp_t;

    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;
    int n_err_seen = 0;

    // Reference model state
    bit       m_primed;
    bit [2:0] m_smp;
    bit       m_locked;
    bit [1:0] m_rel;
    bit [1:0] m_cand;
    int       m_run;
    int       m_mis;
    int       m_loss;
    bit       m_err;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [1:0] code_of(input bit [2:0] f);
        if (f == F_EQ) return 2'b01;
        if (f == F_LT) return 2'b10;
        if (f == F_GT) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_primed = 0; m_smp = 0; m_locked = 0; m_rel = 0; m_cand = 0;
        m_run = 0; m_mis = 0; m_loss = 0; m_err = 0;
        sb_q.delete();
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_step();
        bit       nerr;
        bit       valid;
        bit [1:0] c;
        exp_t     e;
        nerr = 0;
        if (m_primed) begin
            valid = (int'(m_smp[0]) + int'(m_smp[1]) + int'(m_smp[2])) == 1;
            c = code_of(m_smp);
            nerr = !valid;
            if (!m_locked) begin
                if (!valid) m_run = 0;
                else if (c != m_cand) begin m_cand = c; m_run = 1; end
                else begin
                    m_run++;
                    if (m_run >= LOCK_CNT) begin m_locked = 1; m_rel = m_cand; m_mis = 0; end
                end
            end else begin
                if (valid && c == m_rel) m_mis = 0;
                else begin
                    m_mis++;
                    if (m_mis >= UNLOCK_CNT) begin
                        m_locked = 0; m_rel = 0; m_mis = 0;
                        if (m_loss < 255) m_loss++;
                        if (valid) begin m_cand = c; m_run = 1; end
                        else m_run = 0;
                    end
                end
            end
        end
        if (clr_stats) m_loss = 0;
        m_err = nerr;
        m_smp = {PeqQ, PleQ, PgrQ};
        m_primed = 1;
        e.locked = m_locked; e.rel = m_rel; e.err = m_err; e.loss = 8'(m_loss);
        sb_q.push_back(e);
    endtask

    task automatic set_flags(input bit [2:0] f);
        {PeqQ, PleQ, PgrQ} = f;
    endtask

    // One clock: predict, wait for the edge, compare 1 time unit later.
    task automatic tick();
        exp_t e;
        model_step();
        @(posedge sys_clk);
        #1;
        e = sb_q.pop_front();
        check("sb_locked", {7'b0, locked}, {7'b0, e.locked});
        check("sb_rel", {6'b0, rel}, {6'b0, e.rel});
        check("sb_err", {7'b0, err_onehot}, {7'b0, e.err});
        check("sb_loss", loss_cnt, e.loss);
        if (err_onehot === 1'b1) n_err_seen++;
    endtask

    task automatic wait_lock(input bit want, input int budget);
        int n;
        n = 0;
        while (m_locked != want && n < budget) begin
            tick();
            n++;
        end
        check("wait_lock", {7'b0, locked}, {7'b0, want});
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_locked", {7'b0, locked}, 8'd0);
        check("rst_rel", {6'b0, rel}, 8'd0);
        check("rst_err", {7'b0, err_onehot}, 8'd0);
        check("rst_loss", loss_cnt, 8'd0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clr_stats = 1'b0;
        set_flags(F_EQ);

        // Reset held across edges with a valid flag present, then lock on EQ.
        apply_reset();
        n_err_seen = 0;
        repeat (LOCK_CNT) tick();
        check("eq_nolock_e8", {7'b0, locked}, 8'd0);
        tick();
        check("eq_lock_e9", {7'b0, locked}, 8'd1);
        check("eq_rel", {6'b0, rel}, 8'h01);
        check("eq_no_err", 8'(n_err_seen), 8'd0);

        // Short GT excursion below UNLOCK_CNT keeps lock.
        set_flags(F_GT);
        repeat (3) tick();
        set_flags(F_EQ);
        repeat (6) tick();
        check("blip_locked", {7'b0, locked}, 8'd1);
        check("blip_loss", loss_cnt, 8'd0);

        // Four all-zero samples: four error pulses and a loss on the 4th mismatch.
        n_err_seen = 0;
        set_flags(F_NONE);
        repeat (4) tick();
        check("zero_still_locked", {7'b0, locked}, 8'd1);
        set_flags(F_EQ);
        tick();
        check("zero_unlock", {7'b0, locked}, 8'd0);
        check("zero_rel", {6'b0, rel}, 8'h00);
        check("zero_loss", loss_cnt, 8'd1);
        tick();
        check("zero_err_pulses", 8'(n_err_seen), 8'd4);

        // LT run of 5 then GT held: lock after the 9th GT edge.
        apply_reset();
        set_flags(F_LT);
        repeat (5) tick();
        check("lt_nolock", {7'b0, locked}, 8'd0);
        set_flags(F_GT);
        repeat (8) tick();
        check("gt_nolock_e8", {7'b0, locked}, 8'd0);
        tick();
        check("gt_lock_e9", {7'b0, locked}, 8'd1);
        check("gt_rel", {6'b0, rel}, 8'h03);

        // Two-hot samples while locked: error pulses, treated as mismatches.
        n_err_seen = 0;
        set_flags(3'b011);
        repeat (2) tick();
        set_flags(F_GT);
        repeat (3) tick();
        check("twohot_err", 8'(n_err_seen), 8'd2);
        check("twohot_locked", {7'b0, locked}, 8'd1);

        // Move to an EQ lock, clear stats, then force 256 losses.
        set_flags(F_EQ);
        wait_lock(1'b0, 20);
        wait_lock(1'b1, 20);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_loss", loss_cnt, 8'd0);
        for (int i = 0; i < 256; i++) begin
            set_flags(F_GT);
            wait_lock(1'b0, 20);
            set_flags(F_EQ);
            wait_lock(1'b1, 20);
        end
        check("loss_sat", loss_cnt, 8'd255);

        // 257th loss with clr_stats on the same edge: clear wins.
        set_flags(F_GT);
        repeat (4) tick();
        check("pre257_locked", {7'b0, locked}, 8'd1);
        check("pre257_loss", loss_cnt, 8'd255);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("loss257_unlock", {7'b0, locked}, 8'd0);
        check("loss257_clr", loss_cnt, 8'd0);

        // Asynchronous reset mid-cycle while locked, then relock in 9 edges.
        set_flags(F_EQ);
        wait_lock(1'b1, 20);
        #3;
        rst = 1'b1;
        #1;
        check("async_locked", {7'b0, locked}, 8'd0);
        check("async_rel", {6'b0, rel}, 8'd0);
        check("async_loss", loss_cnt, 8'd0);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (LOCK_CNT) tick();
        check("relock_e8", {7'b0, locked}, 8'd0);
        tick();
        check("relock_e9", {7'b0, locked}, 8'd1);
        check("relock_rel", {6'b0, rel}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_cmp_lock.md
CLK_CMP_LOCK -- requirements
Module: clk_cmp_lock

Interface
REQ-001 The block SHALL have one clock, sys_clk; reset is asynchronous and active-high, named rst.
REQ-002 Parameter LOCK_CNT, default 8: consecutive identical valid samples needed to lock; legal range 2..255.
REQ-003 Parameter UNLOCK_CNT, default 4: consecutive non-matching samples needed to drop lock; legal range 1..255.
REQ-004 sys_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 PeqQ  in  1  comparator flag: P frequency equals Q; sys_clk domain.
REQ-007 PleQ  in  1  comparator flag: P frequency lower than Q; sys_clk domain.
REQ-008 PgrQ  in  1  comparator flag: P frequency greater than Q; sys_clk domain.
REQ-009 clr_stats  in  1  single-cycle synchronous clear of loss_cnt.
REQ-010 locked  out  1  a relation has been stable long enough.
REQ-011 rel  out  2  locked relation: 00 none, 01 equal, 10 P<Q, 11 P>Q.
REQ-012 err_onehot  out  1  one-cycle pulse when a sample is not exactly one-hot.
REQ-013 loss_cnt  out  8  saturating count of LOCKED-to-SEARCH transitions.

Function
REQ-014 The block SHALL register {PeqQ, PleQ, PgrQ} once (sample stage); all decisions SHALL use the registered value only.
REQ-015 A sample SHALL be valid only when exactly one flag is high; the encoding SHALL be equal=01, P<Q=10, P>Q=11.
REQ-016 An invalid sample (zero flags high, or two or more) SHALL pulse err_onehot one cycle after the sample is registered; the block SHALL treat the sample as a mismatch.
REQ-017 The FSM SHALL have exactly two states, SEARCH and LOCKED; the reset state SHALL be SEARCH.
REQ-018 In SEARCH, a run counter SHALL:
- load 1 on a valid sample differing from the candidate, and store that sample as the new candidate;
- increment on a valid sample equal to the candidate;
- clear to 0 on an invalid sample.
REQ-019 SEARCH to LOCKED SHALL occur on the edge where the run counter would reach LOCK_CNT.
- On that edge: locked=1, rel=candidate, mismatch counter=0.
REQ-020 Timing: with inputs stable and valid before edge 1, locked SHALL be high after edge LOCK_CNT+1 (edge 1 registers the sample; edges 2.. count).
REQ-021 In LOCKED, the mismatch counter SHALL:
- increment on any sample not equal to rel (including invalid samples);
- clear on any sample equal to rel.
REQ-022 LOCKED to SEARCH SHALL occur on the edge where the mismatch counter would reach UNLOCK_CNT.
- On that edge: locked=0, rel=00, loss_cnt incremented, saturating at 255.
REQ-023 On the LOCKED-to-SEARCH edge, the run counter SHALL restart: 1 with candidate = current sample if valid, else 0.
REQ-024 While locked=1, rel SHALL NOT change.
REQ-025 clr_stats SHALL zero loss_cnt on the next edge; if it coincides with an increment, the clear SHALL win.
REQ-026 Both internal counters SHALL saturate and never wrap.

Reset
REQ-027 While rst is high, the block SHALL hold the following values, regardless of sys_clk:
- state=SEARCH, locked=0, rel=00, err_onehot=0, loss_cnt=0;
- sample register, run counter, mismatch counter and candidate all 0.
REQ-028 Asserting rst mid-operation, including in LOCKED, SHALL immediately force the REQ-027 values without incrementing loss_cnt.
REQ-029 The first sample SHALL be captured on the first sys_clk edge after rst deasserts.

Structure
REQ-030 Shared package clk_cmp_pkg SHALL hold the following, for reuse by the comparator and any consumer:
- the rel encodings (REL_NONE, REL_EQ, REL_LT, REL_GT);
- the FSM state enum.
REQ-031 One sub-module, sat_cnt, a parameterised saturating up-counter with synchronous clear and load, SHALL implement the run, mismatch and loss counters.

Verification
REQ-032 Reset release with PeqQ=1 held, LOCK_CNT=8 -> locked rises after the 9th edge, rel=01, err_onehot never pulses.
REQ-033 PleQ=1 for 5 cycles, then PgrQ=1 held -> no lock during the PleQ run; lock after 9 PgrQ edges with rel=11.
REQ-034 Locked with rel=01, then PgrQ=1 for 3 cycles, then back to PeqQ, UNLOCK_CNT=4 -> locked stays 1, loss_cnt stays 0.
REQ-035 Locked with rel=01, then all flags 0 for 4 cycles -> err_onehot pulses 4 times, locked falls on the 4th mismatch edge, rel=00, loss_cnt=1.
REQ-036 Force 256 lock losses, then assert clr_stats on the same edge as a 257th loss -> loss_cnt holds 255 before the clear, then reads 0.
REQ-037 Assert rst asynchronously mid-cycle while locked -> locked=0 and rel=00 before the next sys_clk edge; relock takes 9 edges after release.
